// File: rtl/up_counter_4bit_ctl_if.sv
// Bus for the controlled up counter: control strobes in, count and status out.
// Signalling: no valid/ready pairs. Every input is a level sampled on each
// rising clk edge (load, clr_ovf and en act as per-edge strobes), and every
// output is valid throughout the cycle that follows the edge that produced it.
interface up_counter_4bit_ctl_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_max;
    logic             sat;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, load, load_val, mod_max, sat, clr_ovf,
        input  count, at_max, wrap, ovf
    );

    modport slave (
        input  en, load, load_val, mod_max, sat, clr_ovf,
        output count, at_max, wrap, ovf
    );
endinterface

// File: rtl/up_counter_4bit_ctl.sv
// Controlled up counter with prescaler, programmable terminal value,
// synchronous load, wrap/saturate mode and wrap/overflow status.
// Per-edge priority is load, then step, then hold.
module up_counter_4bit_ctl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    up_counter_4bit_ctl_if.slave bus
);
    // Prescaler needs at least one bit even when DIV=1 (it then stays at 0).
    localparam int                PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             at_max;

    // Terminal decode; >= also catches a load_val or mod_max change above/below count.
    assign at_max = (count_q >= bus.mod_max);

    // Next-state: load overrides stepping; ovf set beats clr_ovf on the same edge.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        step    = 1'b0;
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (bus.load) begin
            count_d = bus.load_val;
            presc_d = '0;
        end else if (bus.en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (step) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (!bus.sat) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // State registers; async reset also kills a pending wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.at_max = at_max;
    assign bus.wrap   = wrap_q;
    assign bus.ovf    = ovf_q;
endmodule
